// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the multicycle instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// Handshake: master raises imem_req with a stable imem_addr and holds both until a
// cycle with imem_gnt high; data returns later (or in the grant cycle) as a one-cycle
// imem_rvalid pulse with imem_rdata.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit_watchdog.sv
// Fetch timeout counter: cleared at fetch start, counts while a fetch is in flight,
// and flags the cycle whose increment would reach MAX_WAIT.
module instr_fetch_unit_watchdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = en && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: PC register, one memory read per if_en, and an IR that stays
// stable between captures. Misaligned fetches and memory timeouts lock the unit in S_ERR.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_en,
  input  logic                 pc_en,
  input  logic                 pc_src,
  input  logic [31:0]          target,
  instr_fetch_unit_if.master   imem,
  output logic [31:0]          instr,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 instr_valid,
  output logic                 fetch_busy,
  output logic                 misalign_err,
  output logic                 bus_err,
  output fetch_state_t         state
);

  logic timeout;
  logic fetch_start;

  assign pc_plus4    = pc + 32'd4;
  assign fetch_busy  = (state == S_REQ) || (state == S_WAIT);
  // pc_en wins over if_en in S_IDLE, so a same-cycle fetch request is dropped.
  assign fetch_start = (state == S_IDLE) && !pc_en && if_en && (pc[1:0] == 2'b00);

  instr_fetch_unit_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (fetch_start),
    .en      (fetch_busy),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_PC;
      misalign_err   <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pc_en) begin
            pc <= pc_src ? {target[31:1], 1'b0} : pc_plus4;
          end else if (if_en) begin
            if (pc[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
              state        <= S_ERR;
            end else begin
              imem.imem_addr <= pc;
              imem.imem_req  <= 1'b1;
              instr_valid    <= 1'b0;
              state          <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (imem.imem_gnt && imem.imem_rvalid) begin
            imem.imem_req <= 1'b0;
            instr         <= imem.imem_rdata;
            instr_valid   <= 1'b1;
            state         <= S_IDLE;
          end else if (timeout) begin
            imem.imem_req <= 1'b0;
            bus_err       <= 1'b1;
            state         <= S_ERR;
          end else if (imem.imem_gnt) begin
            imem.imem_req <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_IDLE;
          end else if (timeout) begin
            bus_err <= 1'b1;
            state   <= S_ERR;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_ERR;
        end
      endcase
    end
  end

endmodule
